// File: rtl/edge_pulse_counter_pkg.sv
// Shared types and constants for edge_pulse_counter.
package edge_pulse_counter_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StGate = 2'd1,
        StHold = 2'd2
    } state_e;

    localparam int unsigned DefCntW  = 16;
    localparam int unsigned DefGateW = 16;

    // All-ones value of a counter of the given width (width capped at 64).
    function automatic logic [63:0] sat_max(input int unsigned width);
        if (width >= 64) begin
            return '1;
        end
        return (64'd1 << width) - 64'd1;
    endfunction

endpackage

// File: rtl/gate_timer.sv
// Down-counter that measures the gate window. A load value of 0 is treated as 1.
// The last output is high during the final gate cycle.
module gate_timer #(
    parameter int unsigned GATE_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              en,
    input  logic [GATE_W-1:0] load_val,
    output logic              last
);

    logic [GATE_W-1:0] remain_q, remain_d;

    // Next remaining-cycle count: reload on load, otherwise count down while enabled.
    always_comb begin
        remain_d = remain_q;
        if (load) begin
            remain_d = (load_val == '0) ? GATE_W'(1) : load_val;
        end else if (en && (remain_q != '0)) begin
            remain_d = remain_q - GATE_W'(1);
        end
    end

    // Remaining-cycle register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            remain_q <= '0;
        end else begin
            remain_q <= remain_d;
        end
    end

    assign last = (remain_q == GATE_W'(1));

endmodule

// File: rtl/edge_pulse_counter.sv
// Gated event counter for single-cycle edge pulses with a valid/ready result port.
// Optional feature: define EDGE_PULSE_COUNTER_AUTO_RESTART_EN to restart the window
// directly from the result handshake (continuous measurement after the first start).
module edge_pulse_counter
    import edge_pulse_counter_pkg::*;
#(
    parameter int unsigned CNT_W  = DefCntW,
    parameter int unsigned GATE_W = DefGateW
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              edge_pulse,
    input  logic              start,
    input  logic [GATE_W-1:0] gate_cycles,
    output logic              busy,
    output logic              cnt_valid,
    input  logic              cnt_ready,
    output logic [CNT_W-1:0]  cnt_out,
    output logic              overflow
);

    localparam logic [CNT_W-1:0] CntMax = CNT_W'(sat_max(CNT_W));

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              ovf_q, ovf_d;
    logic              timer_load;
    logic              timer_last;

    gate_timer #(
        .GATE_W (GATE_W)
    ) u_gate_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (timer_load),
        .en       (state_q == StGate),
        .load_val (gate_cycles),
        .last     (timer_last)
    );

    // State register; reset abandons any window or held result.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; timer_load marks the start of every new window.
    always_comb begin
        state_d    = state_q;
        timer_load = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d    = StGate;
                    timer_load = 1'b1;
                end
            end
            StGate: begin
                if (timer_last) begin
                    state_d = StHold;
                end
            end
            StHold: begin
                if (cnt_ready) begin
`ifdef EDGE_PULSE_COUNTER_AUTO_RESTART_EN
                    state_d    = StGate;
                    timer_load = 1'b1;
`else
                    state_d    = StIdle;
`endif
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Saturating event count and sticky overflow; only GATE cycles count.
    always_comb begin
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        if (timer_load) begin
            cnt_d = '0;
            ovf_d = 1'b0;
        end else if ((state_q == StGate) && edge_pulse) begin
            if (cnt_q == CntMax) begin
                ovf_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // Count and overflow registers; frozen outside GATE so the result holds in HOLD.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
        end
    end

    // Outputs decoded from state and the result registers.
    always_comb begin
        busy      = (state_q != StIdle);
        cnt_valid = (state_q == StHold);
        cnt_out   = cnt_q;
        overflow  = ovf_q;
    end

endmodule

// File: tb/tb_edge_pulse_counter.sv
// Self-checking bench for edge_pulse_counter: two instances (16-bit and 4-bit count)
// share the same stimulus so saturation can be checked alongside the wide count.
module tb_edge_pulse_counter;

    logic        clk = 1'b0;
    logic        rst;
    logic        edge_pulse;
    logic        start;
    logic        cnt_ready;
    logic [15:0] gate_cycles;

    logic        busy16, valid16, ovf16;
    logic [15:0] cnt16;
    logic        busy4, valid4, ovf4;
    logic [3:0]  cnt4;

    int checks = 0;
    int errors = 0;

    int          obs_lat;
    logic [15:0] obs_cnt16;
    logic        obs_ovf16;
    logic [3:0]  obs_cnt4;
    logic        obs_ovf4;
    logic        obs_busy_ok;

    always #5 clk = ~clk;

    edge_pulse_counter #(
        .CNT_W  (16),
        .GATE_W (16)
    ) dut16 (
        .clk         (clk),
        .rst         (rst),
        .edge_pulse  (edge_pulse),
        .start       (start),
        .gate_cycles (gate_cycles),
        .busy        (busy16),
        .cnt_valid   (valid16),
        .cnt_ready   (cnt_ready),
        .cnt_out     (cnt16),
        .overflow    (ovf16)
    );

    edge_pulse_counter #(
        .CNT_W  (4),
        .GATE_W (16)
    ) dut4 (
        .clk         (clk),
        .rst         (rst),
        .edge_pulse  (edge_pulse),
        .start       (start),
        .gate_cycles (gate_cycles),
        .busy        (busy4),
        .cnt_valid   (valid4),
        .cnt_ready   (cnt_ready),
        .cnt_out     (cnt4),
        .overflow    (ovf4)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: number of pulses within the effective window (0 means 1 cycle).
    function automatic int model_count(input int g, input logic [63:0] pat);
        int n;
        int c;
        n = (g == 0) ? 1 : g;
        c = 0;
        for (int i = 0; i < n && i < 64; i++) begin
            c += int'(pat[i]);
        end
        return c;
    endfunction

    function automatic int model_lat(input int g);
        return ((g == 0) ? 1 : g) + 1;
    endfunction

    // Issues start in the current cycle, drives pat[k-1] on the k-th cycle after it and
    // stops at the first cycle with cnt_valid, recording what the DUTs present there.
    // The caller's edge_pulse value stays on the start cycle itself.
    task automatic do_window(input int g, input logic [63:0] pat, input bit noise);
        start       = 1'b1;
        gate_cycles = g[15:0];
        tick();
        start       = 1'b0;
        obs_lat     = -1;
        obs_busy_ok = 1'b1;
        for (int k = 1; k <= 200; k++) begin
            if (!busy16) obs_busy_ok = 1'b0;
            if (valid16) begin
                obs_lat = k;
                break;
            end
            edge_pulse = (k <= 64) ? pat[k-1] : 1'b0;
            if (noise) start = 1'($urandom % 2);
            tick();
        end
        start      = 1'b0;
        edge_pulse = 1'b0;
        obs_cnt16  = cnt16;
        obs_ovf16  = ovf16;
        obs_cnt4   = cnt4;
        obs_ovf4   = ovf4;
    endtask

    task automatic test_reset();
        rst         = 1'b1;
        start       = 1'b0;
        edge_pulse  = 1'b0;
        cnt_ready   = 1'b0;
        gate_cycles = '0;
        tick();
        tick();
        rst = 1'b0;
        checks++; if (busy16 !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy16); end
        checks++; if (valid16 !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", valid16); end
        checks++; if (cnt16 !== 16'd0) begin errors++; $display("FAIL reset_cnt: got %0d expected 0", cnt16); end
        checks++; if (ovf16 !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b expected 0", ovf16); end
        checks++; if (valid4 !== 1'b0) begin errors++; $display("FAIL reset_valid4: got %b expected 0", valid4); end
    endtask

    task automatic test_basic();
        do_window(10, 64'h155, 1'b0);
        checks++; if (obs_lat !== 11) begin errors++; $display("FAIL basic_latency: got %0d expected 11", obs_lat); end
        checks++; if (obs_cnt16 !== 16'd5) begin errors++; $display("FAIL basic_cnt: got %0d expected 5", obs_cnt16); end
        checks++; if (obs_ovf16 !== 1'b0) begin errors++; $display("FAIL basic_ovf: got %b expected 0", obs_ovf16); end
        checks++; if (obs_busy_ok !== 1'b1) begin errors++; $display("FAIL basic_busy: got %b expected 1", obs_busy_ok); end
        cnt_ready = 1'b1;
        tick();
        cnt_ready = 1'b0;
        checks++; if (valid16 !== 1'b0) begin errors++; $display("FAIL basic_valid_drop: got %b expected 0", valid16); end
        checks++; if (busy16 !== 1'b0) begin errors++; $display("FAIL basic_busy_drop: got %b expected 0", busy16); end
    endtask

    task automatic test_zero_gate();
        edge_pulse = 1'b1;
        do_window(0, '1, 1'b0);
        checks++; if (obs_lat !== 2) begin errors++; $display("FAIL zero_latency: got %0d expected 2", obs_lat); end
        checks++; if (obs_cnt16 !== 16'd1) begin errors++; $display("FAIL zero_cnt: got %0d expected 1", obs_cnt16); end
        cnt_ready = 1'b1;
        tick();
        cnt_ready = 1'b0;
    endtask

    task automatic test_overflow();
        do_window(20, '1, 1'b0);
        checks++; if (obs_cnt4 !== 4'd15) begin errors++; $display("FAIL ovf_cnt4: got %0d expected 15", obs_cnt4); end
        checks++; if (obs_ovf4 !== 1'b1) begin errors++; $display("FAIL ovf_flag4: got %b expected 1", obs_ovf4); end
        checks++; if (obs_cnt16 !== 16'd20) begin errors++; $display("FAIL ovf_cnt16: got %0d expected 20", obs_cnt16); end
        checks++; if (obs_ovf16 !== 1'b0) begin errors++; $display("FAIL ovf_flag16: got %b expected 0", obs_ovf16); end
        cnt_ready = 1'b1;
        tick();
        cnt_ready = 1'b0;
    endtask

    task automatic test_hold_stable();
        logic [63:0] pat;
        logic [15:0] held;
        int exp;
        pat = {$urandom, $urandom};
        for (int i = 0; i < 3; i++) begin
            edge_pulse = 1'b1;
            tick();
        end
        do_window(6, pat, 1'b1);
        exp = model_count(6, pat);
        checks++; if (obs_cnt16 !== 16'(exp)) begin errors++; $display("FAIL hold_cnt: got %0d expected %0d", obs_cnt16, exp); end
        held = 16'(exp);
        for (int i = 0; i < 5; i++) begin
            edge_pulse = 1'b1;
            start      = 1'b1;
            cnt_ready  = 1'b0;
            tick();
            checks++; if (valid16 !== 1'b1) begin errors++; $display("FAIL hold_valid: got %b expected 1", valid16); end
            checks++; if (cnt16 !== held) begin errors++; $display("FAIL hold_stable: got %0d expected %0d", cnt16, held); end
        end
        start      = 1'b0;
        edge_pulse = 1'b0;
        cnt_ready  = 1'b1;
        tick();
        cnt_ready = 1'b0;
        checks++; if (valid16 !== 1'b0) begin errors++; $display("FAIL hold_release: got %b expected 0", valid16); end
        tick();
        tick();
        checks++; if (busy16 !== 1'b0) begin errors++; $display("FAIL hold_no_extra: got %b expected 0", busy16); end
    endtask

    task automatic test_reset_mid();
        start       = 1'b1;
        gate_cycles = 16'd10;
        tick();
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            edge_pulse = 1'b1;
            tick();
        end
        edge_pulse = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if (busy16 !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b expected 0", busy16); end
        checks++; if (valid16 !== 1'b0) begin errors++; $display("FAIL rstmid_valid: got %b expected 0", valid16); end
        checks++; if (cnt16 !== 16'd0) begin errors++; $display("FAIL rstmid_cnt: got %0d expected 0", cnt16); end
        checks++; if (ovf16 !== 1'b0) begin errors++; $display("FAIL rstmid_ovf: got %b expected 0", ovf16); end
        do_window(4, 64'h5, 1'b0);
        checks++; if (obs_lat !== 5) begin errors++; $display("FAIL rstmid_latency: got %0d expected 5", obs_lat); end
        checks++; if (obs_cnt16 !== 16'd2) begin errors++; $display("FAIL rstmid_cnt_after: got %0d expected 2", obs_cnt16); end
        cnt_ready = 1'b1;
        tick();
        cnt_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [63:0] pat;
        int g;
        int exp;
        cnt_ready = 1'b1;
        for (int r = 0; r < 3; r++) begin
            g   = int'($urandom_range(1, 8));
            pat = {$urandom, $urandom};
            do_window(g, pat, 1'b0);
            exp = model_count(g, pat);
            checks++; if (obs_lat !== model_lat(g)) begin errors++; $display("FAIL b2b_latency: got %0d expected %0d", obs_lat, model_lat(g)); end
            checks++; if (obs_cnt16 !== 16'(exp)) begin errors++; $display("FAIL b2b_cnt: got %0d expected %0d", obs_cnt16, exp); end
            tick();
            checks++; if (valid16 !== 1'b0) begin errors++; $display("FAIL b2b_one_cycle: got %b expected 0", valid16); end
            checks++; if (busy16 !== 1'b0) begin errors++; $display("FAIL b2b_idle: got %b expected 0", busy16); end
        end
        cnt_ready = 1'b0;
    endtask

    task automatic test_random();
        logic [63:0] pat;
        int g;
        int exp;
        int e4;
        int dly;
        for (int it = 0; it < 20; it++) begin
            g          = int'($urandom_range(0, 40));
            pat        = {$urandom, $urandom};
            edge_pulse = 1'($urandom % 2);
            do_window(g, pat, 1'b1);
            exp = model_count(g, pat);
            e4  = (exp > 15) ? 15 : exp;
            checks++; if (obs_lat !== model_lat(g)) begin errors++; $display("FAIL rand_latency: got %0d expected %0d", obs_lat, model_lat(g)); end
            checks++; if (obs_cnt16 !== 16'(exp)) begin errors++; $display("FAIL rand_cnt16: got %0d expected %0d", obs_cnt16, exp); end
            checks++; if (obs_cnt4 !== 4'(e4)) begin errors++; $display("FAIL rand_cnt4: got %0d expected %0d", obs_cnt4, e4); end
            checks++; if (obs_ovf4 !== (exp > 15)) begin errors++; $display("FAIL rand_ovf4: got %b expected %b", obs_ovf4, (exp > 15)); end
            checks++; if (obs_ovf16 !== 1'b0) begin errors++; $display("FAIL rand_ovf16: got %b expected 0", obs_ovf16); end
            dly = int'($urandom_range(0, 3));
            for (int d = 0; d < dly; d++) begin
                start      = 1'($urandom % 2);
                edge_pulse = 1'($urandom % 2);
                tick();
                checks++; if (cnt16 !== 16'(exp)) begin errors++; $display("FAIL rand_hold: got %0d expected %0d", cnt16, exp); end
            end
            start      = 1'b0;
            edge_pulse = 1'($urandom % 2);
            cnt_ready  = 1'b1;
            tick();
            cnt_ready  = 1'b0;
            edge_pulse = 1'b0;
            checks++; if (valid16 !== 1'b0) begin errors++; $display("FAIL rand_release: got %b expected 0", valid16); end
        end
    endtask

    task automatic test_auto_restart();
        cnt_ready   = 1'b1;
        start       = 1'b1;
        gate_cycles = 16'd4;
        edge_pulse  = 1'b0;
        tick();
        start = 1'b0;
        for (int k = 1; k <= 25; k++) begin
            checks++; if (valid16 !== (k % 5 == 0)) begin errors++; $display("FAIL auto_valid: got %b expected %b at %0d", valid16, (k % 5 == 0), k); end
            checks++; if (busy16 !== 1'b1) begin errors++; $display("FAIL auto_busy: got %b expected 1 at %0d", busy16, k); end
            if (k % 5 == 0) begin
                checks++; if (cnt16 !== 16'd1) begin errors++; $display("FAIL auto_cnt: got %0d expected 1 at %0d", cnt16, k); end
            end
            edge_pulse = (k % 5 == 1);
            tick();
        end
        edge_pulse = 1'b0;
        cnt_ready  = 1'b0;
    endtask

    initial begin
        test_reset();
`ifdef EDGE_PULSE_COUNTER_AUTO_RESTART_EN
        test_auto_restart();
`else
        test_basic();
        test_zero_gate();
        test_overflow();
        test_hold_stable();
        test_reset_mid();
        test_back_to_back();
        test_random();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
